// File: rtl/stream_divider.sv
// Streaming unsigned divider: two independently handshaked operand channels feed a
// restoring radix-2 divider that returns {quotient, remainder} on a ready/valid output.
module stream_divider #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            dividend_valid,
    output logic                            dividend_ready,
    input  logic [DIVIDEND_W-1:0]           dividend_data,
    input  logic                            divisor_valid,
    output logic                            divisor_ready,
    input  logic [DIVISOR_W-1:0]            divisor_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DIVIDEND_W+DIVISOR_W-1:0] out_data,
    output logic                            out_div_by_zero,
    output logic                            busy
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state_q, state_d;
    logic [DIVIDEND_W-1:0] dividendHold_q, dividendHold_d;
    logic                  dividendFull_q, dividendFull_d;
    logic [DIVISOR_W-1:0]  divisorHold_q, divisorHold_d;
    logic                  divisorFull_q, divisorFull_d;
    logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  divByZero_q, divByZero_d;
    logic [DIVISOR_W:0]    trial;
    logic [DIVISOR_W:0]    diff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            dividendHold_q <= '0;
            dividendFull_q <= 1'b0;
            divisorHold_q  <= '0;
            divisorFull_q  <= 1'b0;
            quotient_q     <= '0;
            remainder_q    <= '0;
            divisor_q      <= '0;
            count_q        <= '0;
            divByZero_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            dividendHold_q <= dividendHold_d;
            dividendFull_q <= dividendFull_d;
            divisorHold_q  <= divisorHold_d;
            divisorFull_q  <= divisorFull_d;
            quotient_q     <= quotient_d;
            remainder_q    <= remainder_d;
            divisor_q      <= divisor_d;
            count_q        <= count_d;
            divByZero_q    <= divByZero_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        dividendHold_d = dividendHold_q;
        dividendFull_d = dividendFull_q;
        divisorHold_d  = divisorHold_q;
        divisorFull_d  = divisorFull_q;
        quotient_d     = quotient_q;
        remainder_d    = remainder_q;
        divisor_d      = divisor_q;
        count_d        = count_q;
        divByZero_d    = divByZero_q;

        // The quotient register doubles as the dividend shifter: its MSB feeds the trial
        // remainder while each new quotient bit enters at the LSB. The borrow bit of diff
        // tells whether the divisor fits.
        trial = {remainder_q, quotient_q[DIVIDEND_W-1]};
        diff  = trial - {1'b0, divisor_q};

        if (dividend_valid && !dividendFull_q) begin
            dividendHold_d = dividend_data;
            dividendFull_d = 1'b1;
        end
        if (divisor_valid && !divisorFull_q) begin
            divisorHold_d = divisor_data;
            divisorFull_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (dividendFull_q && divisorFull_q) begin
                    dividendFull_d = 1'b0;
                    divisorFull_d  = 1'b0;
                    if (divisorHold_q == '0) begin
                        quotient_d  = '1;
                        remainder_d = '0;
                        divByZero_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        quotient_d  = dividendHold_q;
                        remainder_d = '0;
                        divisor_d   = divisorHold_q;
                        count_d     = '0;
                        divByZero_d = 1'b0;
                        state_d     = CALC;
                    end
                end
            end
            CALC: begin
                if (!diff[DIVISOR_W]) begin
                    remainder_d = diff[DIVISOR_W-1:0];
                    quotient_d  = {quotient_q[DIVIDEND_W-2:0], 1'b1};
                end else begin
                    remainder_d = trial[DIVISOR_W-1:0];
                    quotient_d  = {quotient_q[DIVIDEND_W-2:0], 1'b0};
                end
                count_d = count_q + 1'b1;
                if (count_q == LAST_BIT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dividend_ready  = !dividendFull_q;
    assign divisor_ready   = !divisorFull_q;
    assign out_valid       = (state_q == DONE);
    assign out_data        = {quotient_q, remainder_q};
    assign out_div_by_zero = divByZero_q;
    assign busy            = (state_q != IDLE);

endmodule
